// File: rtl/alu32_exec_stage_if.sv
// alu32_exec_stage_if: request/result channels of the ALU execute stage.
// Latency: none, wires only.
// Backpressure: in_ready / out_ready carry the valid/ready handshakes.
// Signals: in_valid/in_ready/in_a/in_b/in_sel/in_tag (request), out_valid/out_ready/
//   out_y/out_zero/out_carry/out_overflow/out_tag (result). The slave modport is the stage.
interface alu32_exec_stage_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [3:0]       in_sel;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_y;
    logic             out_zero;
    logic             out_carry;
    logic             out_overflow;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_sel, in_tag, out_ready,
        input  in_ready, out_valid, out_y, out_zero, out_carry, out_overflow, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sel, in_tag, out_ready,
        output in_ready, out_valid, out_y, out_zero, out_carry, out_overflow, out_tag
    );
endinterface

// File: rtl/alu32_exec_stage.sv
// alu32_exec_stage: two-stage valid/ready execute stage around a 32-bit ALU (alu32).
// Latency: request accepted at edge N is presented on out_* after edge N+1; 1 op/cycle.
// Backpressure: out_ready low freezes out_*; in_ready drops once both stages are full.
// Ports: clk, rst_n (async, active low), bus (alu32_exec_stage_if.slave: in_* request,
//   out_* result). Build macro ALU_EXEC_STATS_EN adds outputs ops_done and ovf_count,
//   saturating retire / overflow-retire counters.

// alu32: combinational ALU. ADDER_TYPE 0 = ripple carry, 1 = 4-bit-group carry lookahead.
// Ops: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 SLT (signed), 6 SLL, 7 SRL, 8 SRA, 9 NOR.
// carry/overflow are meaningful for ADD and SUB only and read 0 for every other op.
module alu32 #(
    parameter int ADDER_TYPE = 0
) (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  sel,
    output logic [31:0] y,
    output logic        zero,
    output logic        carry,
    output logic        overflow
);
    localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_XOR = 4'b0010,
                           OP_ADD = 4'b0011, OP_SUB = 4'b0100, OP_SLT = 4'b0101,
                           OP_SLL = 4'b0110, OP_SRL = 4'b0111, OP_SRA = 4'b1000,
                           OP_NOR = 4'b1001;

    logic        sub;
    logic [31:0] bx;
    logic [31:0] sum;
    logic [32:0] c;
    logic        add_ovf;

    // SUB and SLT both compute a + ~b + 1, so carry reads as "no borrow".
    assign sub = (sel == OP_SUB) || (sel == OP_SLT);
    assign bx  = sub ? ~b : b;

    generate
        if (ADDER_TYPE == 0) begin : g_rca
            always_comb begin
                c    = '0;
                sum  = '0;
                c[0] = sub;
                for (int i = 0; i < 32; i++) begin
                    sum[i]   = a[i] ^ bx[i] ^ c[i];
                    c[i+1]   = (a[i] & bx[i]) | ((a[i] ^ bx[i]) & c[i]);
                end
            end
        end else begin : g_cla
            logic [31:0] g;
            logic [31:0] p;
            always_comb begin
                g    = a & bx;
                p    = a ^ bx;
                c    = '0;
                c[0] = sub;
                // Carries inside a group come straight from the group carry-in; only
                // the group carry-out ripples on to the next group.
                for (int k = 0; k < 8; k++) begin
                    c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
                    c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                             | (p[4*k+1] & p[4*k] & c[4*k]);
                    c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                             | (p[4*k+2] & p[4*k+1] & g[4*k])
                             | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
                    c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                             | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                             | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                             | ((&p[4*k +: 4]) & c[4*k]);
                end
                sum = p ^ c[31:0];
            end
        end
    endgenerate

    assign add_ovf = c[32] ^ c[31];

    always_comb begin
        y        = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (sel)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOR: y = ~(a | b);
            OP_ADD, OP_SUB: begin
                y        = sum;
                carry    = c[32];
                overflow = add_ovf;
            end
            // Sign of the true difference is the sum sign corrected by overflow.
            OP_SLT: y = {31'd0, sum[31] ^ add_ovf};
            OP_SLL: y = a << b[4:0];
            OP_SRL: y = a >> b[4:0];
            OP_SRA: y = $signed(a) >>> b[4:0];
            default: y = '0;
        endcase
    end

    assign zero = (y == 32'd0);
endmodule

module alu32_exec_stage #(
    parameter int ADDER_TYPE = 0,
    parameter int TAG_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    alu32_exec_stage_if.slave  bus
`ifdef ALU_EXEC_STATS_EN
    ,
    output logic [31:0]        ops_done,
    output logic [31:0]        ovf_count
`endif
);
    logic             s1_valid;
    logic [31:0]      s1_a;
    logic [31:0]      s1_b;
    logic [3:0]       s1_sel;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [31:0]      s2_y;
    logic             s2_zero;
    logic             s2_carry;
    logic             s2_overflow;
    logic [TAG_W-1:0] s2_tag;

    logic             s2_adv;
    logic             accept;
    logic             retire;
    logic [31:0]      alu_y;
    logic             alu_zero;
    logic             alu_carry;
    logic             alu_overflow;

    // S1 may move into S2 when S2 is empty or is being drained this same edge.
    assign s2_adv      = s1_valid && (!s2_valid || bus.out_ready);
    assign bus.in_ready = !s1_valid || s2_adv;
    assign accept      = bus.in_valid && bus.in_ready;
    assign retire      = s2_valid && bus.out_ready;

    alu32 #(.ADDER_TYPE(ADDER_TYPE)) u_alu (
        .a        (s1_a),
        .b        (s1_b),
        .sel      (s1_sel),
        .y        (alu_y),
        .zero     (alu_zero),
        .carry    (alu_carry),
        .overflow (alu_overflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_sel   <= '0;
            s1_tag   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= bus.in_a;
            s1_b     <= bus.in_b;
            s1_sel   <= bus.in_sel;
            s1_tag   <= bus.in_tag;
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // S2 data only changes on s2_adv, so a stalled result stays put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid    <= 1'b0;
            s2_y        <= '0;
            s2_zero     <= 1'b0;
            s2_carry    <= 1'b0;
            s2_overflow <= 1'b0;
            s2_tag      <= '0;
        end else if (s2_adv) begin
            s2_valid    <= 1'b1;
            s2_y        <= alu_y;
            s2_zero     <= alu_zero;
            s2_carry    <= alu_carry;
            s2_overflow <= alu_overflow;
            s2_tag      <= s1_tag;
        end else if (retire) begin
            s2_valid    <= 1'b0;
        end
    end

    assign bus.out_valid    = s2_valid;
    assign bus.out_y        = s2_y;
    assign bus.out_zero     = s2_zero;
    assign bus.out_carry    = s2_carry;
    assign bus.out_overflow = s2_overflow;
    assign bus.out_tag      = s2_tag;

`ifdef ALU_EXEC_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_done  <= '0;
            ovf_count <= '0;
        end else if (retire) begin
            if (ops_done != 32'hFFFF_FFFF) begin
                ops_done <= ops_done + 32'd1;
            end
            if (s2_overflow && (ovf_count != 32'hFFFF_FFFF)) begin
                ovf_count <= ovf_count + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_alu32_exec_stage.sv
// tb_alu32_exec_stage: directed + streamed checks of alu32_exec_stage, two instances
// (ripple and lookahead adders) driven in lockstep from one request stream.
module tb_alu32_exec_stage;
    localparam int TAG_W = 4;
    localparam logic [3:0] ADD = 4'b0011;
    localparam logic [3:0] SUB = 4'b0100;

    typedef struct packed {
        logic [31:0]      y;
        logic [TAG_W-1:0] tag;
        logic             ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_got    = 0;
    int   n_ovf_model = 0;
    exp_t q[$];

    alu32_exec_stage_if #(.TAG_W(TAG_W)) bus0 ();
    alu32_exec_stage_if #(.TAG_W(TAG_W)) bus1 ();

    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.in_a      = bus0.in_a;
    assign bus1.in_b      = bus0.in_b;
    assign bus1.in_sel    = bus0.in_sel;
    assign bus1.in_tag    = bus0.in_tag;
    assign bus1.out_ready = bus0.out_ready;

`ifdef ALU_EXEC_STATS_EN
    logic [31:0] ops_done0, ovf_count0, ops_done1, ovf_count1;
`endif

    alu32_exec_stage #(.ADDER_TYPE(0), .TAG_W(TAG_W)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
`ifdef ALU_EXEC_STATS_EN
        ,
        .ops_done  (ops_done0),
        .ovf_count (ovf_count0)
`endif
    );

    alu32_exec_stage #(.ADDER_TYPE(1), .TAG_W(TAG_W)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
`ifdef ALU_EXEC_STATS_EN
        ,
        .ops_done  (ops_done1),
        .ovf_count (ovf_count1)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", nm, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic is_sub, input logic [TAG_W-1:0] tag);
        exp_t        e;
        logic [31:0] y;
        y     = is_sub ? (a - b) : (a + b);
        e.y   = y;
        e.tag = tag;
        e.ovf = is_sub ? ((a[31] != b[31]) && (y[31] != a[31]))
                       : ((a[31] == b[31]) && (y[31] != a[31]));
        return e;
    endfunction

    // One request through an otherwise idle stage with out_ready held high.
    task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] sel, input logic [TAG_W-1:0] tag,
                          input logic [31:0] ey, input logic ez, input logic ec, input logic eo);
        @(negedge clk);
        bus0.in_valid  = 1'b1;
        bus0.in_a      = a;
        bus0.in_b      = b;
        bus0.in_sel    = sel;
        bus0.in_tag    = tag;
        bus0.out_ready = 1'b1;
        chk({nm, "_in_ready"}, 64'(bus0.in_ready), 64'd1);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        bus0.in_a     = 32'hDEAD_BEEF;
        bus0.in_b     = 32'hDEAD_BEEF;
        chk({nm, "_latency"}, 64'(bus0.out_valid), 64'd0);
        @(negedge clk);
        chk({nm, "_valid"}, 64'(bus0.out_valid), 64'd1);
        chk({nm, "_y"},     64'(bus0.out_y), 64'(ey));
        chk({nm, "_zero"},  64'(bus0.out_zero), 64'(ez));
        chk({nm, "_carry"}, 64'(bus0.out_carry), 64'(ec));
        chk({nm, "_ovf"},   64'(bus0.out_overflow), 64'(eo));
        chk({nm, "_tag"},   64'(bus0.out_tag), 64'(tag));
        chk({nm, "_cla_y"}, 64'(bus1.out_y), 64'(ey));
        chk({nm, "_cla_c"}, 64'(bus1.out_carry), 64'(ec));
        chk({nm, "_cla_o"}, 64'(bus1.out_overflow), 64'(eo));
    endtask

    // One streaming cycle: drive at negedge, score any retire, record any accept.
    // Returns before the following posedge so callers can inspect the same cycle.
    task automatic step(input logic iv, input logic [31:0] a, input logic [31:0] b,
                        input logic is_sub, input logic [TAG_W-1:0] tag,
                        input logic ordy, output logic acc);
        exp_t e;
        @(negedge clk);
        bus0.in_valid  = iv;
        bus0.in_a      = a;
        bus0.in_b      = b;
        bus0.in_sel    = is_sub ? SUB : ADD;
        bus0.in_tag    = tag;
        bus0.out_ready = ordy;
        #1;
        if (bus0.out_valid && bus0.out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_result", 64'(bus0.out_valid), 64'd0);
            end else begin
                e = q.pop_front();
                n_got++;
                if (e.ovf) n_ovf_model++;
                chk("stream_y",     64'(bus0.out_y), 64'(e.y));
                chk("stream_tag",   64'(bus0.out_tag), 64'(e.tag));
                chk("stream_ovf",   64'(bus0.out_overflow), 64'(e.ovf));
                chk("stream_cla_y", 64'(bus1.out_y), 64'(e.y));
            end
        end
        acc = iv && bus0.in_ready;
        if (acc) q.push_back(model(a, b, is_sub, tag));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus0.in_valid = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] va;
        logic [31:0] vb;
        logic        acc;
        int          sent;

        bus0.in_valid  = 1'b0;
        bus0.in_a      = '0;
        bus0.in_b      = '0;
        bus0.in_sel    = '0;
        bus0.in_tag    = '0;
        bus0.out_ready = 1'b0;

        // Reset state
        #1;
        chk("rst_out_valid", 64'(bus0.out_valid), 64'd0);
        chk("rst_out_y",     64'(bus0.out_y), 64'd0);
        chk("rst_out_zero",  64'(bus0.out_zero), 64'd0);
        chk("rst_out_carry", 64'(bus0.out_carry), 64'd0);
        chk("rst_out_ovf",   64'(bus0.out_overflow), 64'd0);
        chk("rst_out_tag",   64'(bus0.out_tag), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready",  64'(bus0.in_ready), 64'd1);

        // Directed single operations
        run_op("add_5_3",     32'd5,          32'd3,          ADD,     4'h1, 32'd8,          1'b0, 1'b0, 1'b0);
        run_op("sub_5_5",     32'd5,          32'd5,          SUB,     4'h2, 32'd0,          1'b1, 1'b1, 1'b0);
        run_op("sub_min_1",   32'h8000_0000,  32'd1,          SUB,     4'h3, 32'h7FFF_FFFF,  1'b0, 1'b1, 1'b1);
        run_op("add_wrap",    32'hFFFF_FFFF,  32'd1,          ADD,     4'h4, 32'd0,          1'b1, 1'b1, 1'b0);
        run_op("add_ovf",     32'h7FFF_FFFF,  32'd1,          ADD,     4'h5, 32'h8000_0000,  1'b0, 1'b0, 1'b1);
        run_op("and",         32'h0000_F0F0,  32'h0000_FF00,  4'b0000, 4'h6, 32'h0000_F000,  1'b0, 1'b0, 1'b0);
        run_op("slt_neg",     32'hFFFF_FFFF,  32'd1,          4'b0101, 4'h7, 32'd1,          1'b0, 1'b0, 1'b0);

        // Backpressure: tags 0..7, out_ready low for the first 5 cycles
        n_got = 0;
        sent  = 0;
        for (int cyc = 0; cyc < 100 && n_got < 8; cyc++) begin
            va = 32'(sent) * 32'h1111_1111;
            vb = 32'd3 + 32'(sent);
            step(sent < 8, va, vb, sent[0], sent[3:0], cyc >= 5, acc);
            if (acc) sent++;
            if (cyc >= 2 && cyc <= 4) begin
                chk("bp_in_ready",     64'(bus0.in_ready), 64'd0);
                chk("bp_cla_in_ready", 64'(bus1.in_ready), 64'd0);
                chk("bp_out_valid",    64'(bus0.out_valid), 64'd1);
                chk("bp_out_y_hold",   64'(bus0.out_y), 64'd3);
                chk("bp_out_tag_hold", 64'(bus0.out_tag), 64'd0);
                chk("bp_accepts",      64'(sent), 64'd2);
            end
        end
        chk("bp_all_results", 64'(n_got), 64'd8);

        // Random ADD/SUB stream with random valid/ready
        pulse_reset();
        n_got       = 0;
        n_ovf_model = 0;
        sent        = 0;
`ifdef ALU_EXEC_STATS_EN
        #1;
        chk("stats_rst_ops", 64'(ops_done0), 64'd0);
        chk("stats_rst_ovf", 64'(ovf_count0), 64'd0);
`endif
        for (int cyc = 0; cyc < 10000 && n_got < 1000; cyc++) begin
            va = $urandom();
            vb = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : $urandom();
            step((sent < 1000) && ($urandom_range(0, 3) != 0), va, vb,
                 $urandom_range(0, 1) == 1, sent[3:0], $urandom_range(0, 3) != 0, acc);
            if (acc) sent++;
        end
        chk("rand_all_results", 64'(n_got), 64'd1000);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        chk("rand_drained", 64'(q.size()), 64'd0);
`ifdef ALU_EXEC_STATS_EN
        chk("stats_ops_done",      64'(ops_done0), 64'd1000);
        chk("stats_ovf_count",     64'(ovf_count0), 64'(n_ovf_model));
        chk("stats_cla_ops_done",  64'(ops_done1), 64'd1000);
        chk("stats_cla_ovf_count", 64'(ovf_count1), 64'(n_ovf_model));
`endif

        // Reset with two requests in flight
        step(1'b1, 32'd10, 32'd20, 1'b0, 4'hA, 1'b0, acc);
        step(1'b1, 32'd30, 32'd40, 1'b1, 4'hB, 1'b0, acc);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        chk("flush_pre_valid", 64'(bus0.out_valid), 64'd1);
        chk("flush_pre_full",  64'(bus0.in_ready), 64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("flush_valid_now", 64'(bus0.out_valid), 64'd0);
        chk("flush_y_now",     64'(bus0.out_y), 64'd0);
        chk("flush_tag_now",   64'(bus0.out_tag), 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus0.out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            chk("flush_no_result", 64'(bus0.out_valid | bus1.out_valid), 64'd0);
        end
`ifdef ALU_EXEC_STATS_EN
        chk("flush_stats_ops", 64'(ops_done0), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
